fifo_cascade_chain: RTL and testbench
=====================================

FIFO_CASCADE_CHAIN -- requirements
Module: fifo_cascade_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 20, data word width in bits (1..40).
REQ-002 SHALL have parameter DEPH, default 3, number of cascaded storage stages (1..16).
REQ-003 SHALL have parameter STAGE_ADDR_W, default 9, log2 of entries per stage.
REQ-004 SHALL have parameter ALMOST_FULL_OFFSET, default 3, almost-full threshold distance from capacity.
REQ-005 SHALL have parameter ALMOST_EMPTY_OFFSET, default 15, almost-empty threshold level.
REQ-006 SHALL have rclk  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have rst  input  1  reset; synchronous, active-low.
REQ-008 SHALL have PUSH_i  input  1  write request.
REQ-009 SHALL have DI  input  WIDTH  write data, sampled with PUSH_i.
REQ-010 SHALL have POP_i  input  1  read request.
REQ-011 SHALL have DO  output  WIDTH  read data.
REQ-012 SHALL have DO_VALID_o  output  1  DO carries a popped word this cycle.
REQ-013 SHALL have FULL_o, EMPTY_o, ALMOST_FULL_o, ALMOST_EMPTY_o  output  1 each  status flags.
REQ-014 SHALL have LEVEL_o  output  clog2(CAP+1)  stored word count.
REQ-015 SHALL have WR_ERR_o, RD_ERR_o  output  1 each  single-cycle rejected-request pulses.

Function
REQ-016 SHALL provide capacity CAP = DEPH * 2^STAGE_ADDR_W words as one ordered FIFO.
REQ-017 SHALL use global write/read pointers 0..CAP-1; upper bits select the stage, lower STAGE_ADDR_W bits the address; pointer at CAP-1 wraps to 0, including non-power-of-two DEPH.
REQ-018 SHALL accept a push when !FULL_o, or when FULL_o and an accepted pop occurs in the same cycle.
REQ-019 SHALL accept a pop only when !EMPTY_o; a pop on empty is rejected even with a simultaneous push.
REQ-020 SHALL present popped data on DO with DO_VALID_o high exactly one cycle after an accepted pop; DO holds its last value otherwise.
REQ-021 SHALL update LEVEL_o the cycle after an accepted push (+1) or pop (-1); both together leave it unchanged.
REQ-022 SHALL derive flags from the registered level: FULL_o = (LEVEL_o==CAP), EMPTY_o = (LEVEL_o==0), ALMOST_FULL_o = (LEVEL_o >= CAP-ALMOST_FULL_OFFSET), ALMOST_EMPTY_o = (LEVEL_o <= ALMOST_EMPTY_OFFSET).
REQ-023 SHALL pulse WR_ERR_o one cycle after a rejected push and RD_ERR_o one cycle after a rejected pop; a rejected request SHALL change no state.
REQ-024 SHALL preserve strict FIFO order across stage boundaries and across wrap at CAP.

Reset
REQ-025 SHALL, with rst low at a clock edge, clear pointers, LEVEL_o, DO, DO_VALID_o, WR_ERR_o and RD_ERR_o to 0, set EMPTY_o=1, ALMOST_EMPTY_o=1, FULL_o=0, ALMOST_FULL_o=0.
REQ-026 SHALL ignore PUSH_i and POP_i while rst is low; reset mid-operation discards all stored words; storage contents are not cleared.

Configuration
REQ-027 SHALL, with FIFO_CASCADE_OVERWRITE_EN defined, accept a push when FULL_o with no pop by discarding the oldest word (read pointer advances), keeping LEVEL_o = CAP and not pulsing WR_ERR_o.
REQ-028 SHALL, without FIFO_CASCADE_OVERWRITE_EN, reject push-on-full as in REQ-023.

Structure
REQ-029 SHALL place CAP/pointer-width helper functions and max-DEPH/max-WIDTH constants in shared package ila_fifo_pkg.
REQ-030 SHALL instantiate DEPH copies of sub-module ila_fifo_stage (simple dual-port RAM, 2^STAGE_ADDR_W x WIDTH, registered read) and a registered stage-select output mux.

Verification (WIDTH=8, DEPH=3, STAGE_ADDR_W=4, CAP=48, offsets 3/15)
REQ-031 SHALL cover: push 0..47 -> FULL_o=1, LEVEL_o=48, ALMOST_FULL_o from LEVEL_o=45; pop 48 -> DO 0..47 in order, EMPTY_o=1.
REQ-032 SHALL cover: 100 push/pop ops with level kept near 10 -> pointers wrap past 47 to 0, no data error, LEVEL_o stable.
REQ-033 SHALL cover: push when full -> WR_ERR_o pulse, LEVEL_o=48 (no macro); with macro, push 0x99 then 48 pops -> DO 1..47, 0x99.
REQ-034 SHALL cover: pop when empty with simultaneous push of 0x5A -> RD_ERR_o pulse, LEVEL_o=1, next pop returns 0x5A.
REQ-035 SHALL cover: full FIFO, simultaneous push 0xAA and pop -> LEVEL_o stays 48, no WR_ERR_o, 0xAA emerges last.
REQ-036 SHALL cover: rst low after 20 pushes -> LEVEL_o=0, EMPTY_o=1, DO_VALID_o=0 next cycle; subsequent push/pop returns new data only.

Source files
------------

// File: rtl/ila_fifo_pkg.sv
// ila_fifo_pkg: shared sizing helpers and limits for the cascaded FIFO.
//   fifo_cap    : total words = stages << per-stage address bits
//   ptr_width   : bits needed for a global pointer 0..cap-1
//   level_width : bits needed for a level 0..cap
//   sel_width   : bits needed to select one of the stages
package ila_fifo_pkg;

    localparam int unsigned MAX_DEPH  = 16;
    localparam int unsigned MAX_WIDTH = 40;

    function automatic int unsigned fifo_cap(input int unsigned deph, input int unsigned aw);
        return deph << aw;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned cap);
        return (cap > 1) ? $clog2(cap) : 1;
    endfunction

    function automatic int unsigned level_width(input int unsigned cap);
        return $clog2(cap + 1);
    endfunction

    function automatic int unsigned sel_width(input int unsigned deph);
        return (deph > 1) ? $clog2(deph) : 1;
    endfunction

endpackage

// File: rtl/ila_fifo_stage.sv
// ila_fifo_stage: one storage stage, simple dual-port RAM of 2^ADDR_W x WIDTH
// with a registered read port.
//   rclk    : clock (rising edge)
//   rst     : synchronous active-low reset, clears only the read register
//   wr_en   : write strobe; wr_addr / wr_data
//   rd_en   : read strobe; rd_addr selects the word, rd_data holds it
//             until the next read
module ila_fifo_stage #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Storage is never reset.
    always_ff @(posedge rclk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read-before-write on an address collision: the old word is returned,
    // which is what a simultaneous push/pop on a full FIFO needs.
    always_ff @(posedge rclk) begin
        if (!rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/fifo_cascade_chain.sv
// fifo_cascade_chain: one ordered FIFO built from DEPH cascaded RAM stages.
// Global pointers run 0..CAP-1 (CAP = DEPH * 2^STAGE_ADDR_W); the upper
// pointer bits select the stage, the lower STAGE_ADDR_W bits the address.
//   rclk            : clock (rising edge)
//   rst             : synchronous active-low reset
//   PUSH_i, DI      : write request and data
//   POP_i           : read request
//   DO, DO_VALID_o  : popped word, valid the cycle after an accepted pop
//   FULL_o, EMPTY_o, ALMOST_FULL_o, ALMOST_EMPTY_o : flags from LEVEL_o
//   LEVEL_o         : stored word count
//   WR_ERR_o, RD_ERR_o : one-cycle pulses for rejected requests
// Optional build macro FIFO_CASCADE_OVERWRITE_EN: push on full without a pop
// discards the oldest word instead of being rejected.
module fifo_cascade_chain
    import ila_fifo_pkg::*;
#(
    parameter int unsigned WIDTH               = 20,
    parameter int unsigned DEPH                = 3,
    parameter int unsigned STAGE_ADDR_W        = 9,
    parameter int unsigned ALMOST_FULL_OFFSET  = 3,
    parameter int unsigned ALMOST_EMPTY_OFFSET = 15
) (
    input  logic             rclk,
    input  logic             rst,
    input  logic             PUSH_i,
    input  logic [WIDTH-1:0] DI,
    input  logic             POP_i,
    output logic [WIDTH-1:0] DO,
    output logic             DO_VALID_o,
    output logic             FULL_o,
    output logic             EMPTY_o,
    output logic             ALMOST_FULL_o,
    output logic             ALMOST_EMPTY_o,
    output logic [level_width(fifo_cap(DEPH, STAGE_ADDR_W))-1:0] LEVEL_o,
    output logic             WR_ERR_o,
    output logic             RD_ERR_o
);

    localparam int unsigned CAP   = fifo_cap(DEPH, STAGE_ADDR_W);
    localparam int unsigned PTR_W = ptr_width(CAP);
    localparam int unsigned LVL_W = level_width(CAP);
    localparam int unsigned SEL_W = sel_width(DEPH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic [SEL_W-1:0] wr_sel, rd_sel, sel_q;
    logic [WIDTH-1:0] stage_q [DEPH];

    logic push_ok, pop_ok, rd_adv;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == CAP - 1) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        wr_sel = SEL_W'(wr_ptr >> STAGE_ADDR_W);
        rd_sel = SEL_W'(rd_ptr >> STAGE_ADDR_W);
    end

    // Requests are qualified with rst so nothing moves during reset.
    always_comb begin
        pop_ok = rst && POP_i && !EMPTY_o;
`ifdef FIFO_CASCADE_OVERWRITE_EN
        push_ok = rst && PUSH_i;
        // A push on full with no pop evicts the oldest word.
        rd_adv  = pop_ok || (push_ok && FULL_o);
`else
        push_ok = rst && PUSH_i && (!FULL_o || pop_ok);
        rd_adv  = pop_ok;
`endif
    end

    always_ff @(posedge rclk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            sel_q      <= '0;
            DO_VALID_o <= 1'b0;
            WR_ERR_o   <= 1'b0;
            RD_ERR_o   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            if (rd_adv)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !rd_adv)
                level_q <= level_q + LVL_W'(1);
            else if (rd_adv && !push_ok)
                level_q <= level_q - LVL_W'(1);
            if (pop_ok)
                sel_q <= rd_sel;
            DO_VALID_o <= pop_ok;
            WR_ERR_o   <= PUSH_i && !push_ok;
            RD_ERR_o   <= POP_i && !pop_ok;
        end
    end

    for (genvar g = 0; g < DEPH; g++) begin : g_stage
        ila_fifo_stage #(
            .WIDTH  (WIDTH),
            .ADDR_W (STAGE_ADDR_W)
        ) u_stage (
            .rclk    (rclk),
            .rst     (rst),
            .wr_en   (push_ok && (wr_sel == SEL_W'(g))),
            .wr_addr (wr_ptr[STAGE_ADDR_W-1:0]),
            .wr_data (DI),
            .rd_en   (pop_ok && (rd_sel == SEL_W'(g))),
            .rd_addr (rd_ptr[STAGE_ADDR_W-1:0]),
            .rd_data (stage_q[g])
        );
    end

    // Each stage read register and the registered select only change on an
    // accepted pop, so DO holds its last popped word between pops.
    always_comb begin
        DO = stage_q[sel_q];
    end

    always_comb begin
        LEVEL_o        = level_q;
        FULL_o         = (32'(level_q) == CAP);
        EMPTY_o        = (level_q == '0);
        ALMOST_FULL_o  = (32'(level_q) >= CAP - ALMOST_FULL_OFFSET);
        ALMOST_EMPTY_o = (32'(level_q) <= ALMOST_EMPTY_OFFSET);
    end

endmodule

// File: tb/tb_fifo_cascade_chain.sv
module tb_fifo_cascade_chain;

    logic       rclk = 1'b0;
    logic       rst;
    logic       PUSH_i;
    logic [7:0] DI;
    logic       POP_i;
    logic [7:0] DO;
    logic       DO_VALID_o;
    logic       FULL_o, EMPTY_o, ALMOST_FULL_o, ALMOST_EMPTY_o;
    logic [5:0] LEVEL_o;
    logic       WR_ERR_o, RD_ERR_o;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    fifo_cascade_chain #(
        .WIDTH               (8),
        .DEPH                (3),
        .STAGE_ADDR_W        (4),
        .ALMOST_FULL_OFFSET  (3),
        .ALMOST_EMPTY_OFFSET (15)
    ) dut (
        .rclk           (rclk),
        .rst            (rst),
        .PUSH_i         (PUSH_i),
        .DI             (DI),
        .POP_i          (POP_i),
        .DO             (DO),
        .DO_VALID_o     (DO_VALID_o),
        .FULL_o         (FULL_o),
        .EMPTY_o        (EMPTY_o),
        .ALMOST_FULL_o  (ALMOST_FULL_o),
        .ALMOST_EMPTY_o (ALMOST_EMPTY_o),
        .LEVEL_o        (LEVEL_o),
        .WR_ERR_o       (WR_ERR_o),
        .RD_ERR_o       (RD_ERR_o)
    );

    always #5 rclk = ~rclk;

    // Inputs change on the falling edge; the call returns at the next falling
    // edge, so outputs then reflect the rising edge that sampled the inputs.
    task automatic drive(input logic p, input logic [7:0] d, input logic q);
        PUSH_i = p;
        DI     = d;
        POP_i  = q;
        @(negedge rclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input int unsigned lvl);
        chk({tag, ".level"}, 32'(LEVEL_o), lvl);
        chk({tag, ".full"},  32'(FULL_o), 32'(lvl == 48));
        chk({tag, ".empty"}, 32'(EMPTY_o), 32'(lvl == 0));
        chk({tag, ".afull"}, 32'(ALMOST_FULL_o), 32'(lvl >= 45));
        chk({tag, ".aempty"}, 32'(ALMOST_EMPTY_o), 32'(lvl <= 15));
    endtask

    task automatic chk_pop(input string tag, input logic [7:0] exp);
        chk({tag, ".valid"}, 32'(DO_VALID_o), 32'd1);
        chk({tag, ".do"}, 32'(DO), 32'(exp));
    endtask

    logic [7:0] exp_word;
    logic [7:0] wr_val, rd_val;

    initial begin
        rst = 1'b0;
        PUSH_i = 1'b0; DI = '0; POP_i = 1'b0;
        @(negedge rclk);
        drive(1'b1, 8'hFF, 1'b1);          // ignored while in reset

        // Reset state
        chk_flags("rst", 0);
        chk("rst.do", 32'(DO), 32'd0);
        chk("rst.valid", 32'(DO_VALID_o), 32'd0);
        chk("rst.wrerr", 32'(WR_ERR_o), 32'd0);
        chk("rst.rderr", 32'(RD_ERR_o), 32'd0);
        rst = 1'b1;

        // Fill 0..47: flags tracked at every level
        for (int i = 0; i < 48; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            chk_flags("fill", i + 1);
            chk("fill.valid", 32'(DO_VALID_o), 32'd0);
        end

        // Push on full
        drive(1'b1, 8'h99, 1'b0);
        chk("pfull.level", 32'(LEVEL_o), 32'd48);
`ifdef FIFO_CASCADE_OVERWRITE_EN
        chk("pfull.wrerr", 32'(WR_ERR_o), 32'd0);
`else
        chk("pfull.wrerr", 32'(WR_ERR_o), 32'd1);
`endif
        drive(1'b0, 8'h00, 1'b0);
        chk("pfull.wrerr_clr", 32'(WR_ERR_o), 32'd0);
        chk("pfull.valid", 32'(DO_VALID_o), 32'd0);

        // Drain 48 in order, across stage boundaries
        for (int i = 0; i < 48; i++) begin
`ifdef FIFO_CASCADE_OVERWRITE_EN
            exp_word = (i < 47) ? 8'(i + 1) : 8'h99;
`else
            exp_word = 8'(i);
`endif
            drive(1'b0, 8'h00, 1'b1);
            chk_pop("drain", exp_word);
            chk("drain.level", 32'(LEVEL_o), 32'(47 - i));
        end
        chk_flags("drained", 0);
        drive(1'b0, 8'h00, 1'b0);
        chk("drained.valid", 32'(DO_VALID_o), 32'd0);
        chk("drained.hold", 32'(DO), 32'(exp_word));

        // Full, simultaneous push 0xAA + pop
        for (int i = 0; i < 48; i++)
            drive(1'b1, 8'(i), 1'b0);
        chk("refill.full", 32'(FULL_o), 32'd1);
        drive(1'b1, 8'hAA, 1'b1);
        chk_pop("fpp", 8'h00);
        chk("fpp.level", 32'(LEVEL_o), 32'd48);
        chk("fpp.wrerr", 32'(WR_ERR_o), 32'd0);
        for (int i = 1; i < 48; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk_pop("fppdrain", 8'(i));
        end
        drive(1'b0, 8'h00, 1'b1);
        chk_pop("fpp.last", 8'hAA);
        chk_flags("fpp.end", 0);

        // Pop on empty with simultaneous push
        drive(1'b1, 8'h5A, 1'b1);
        chk("pe.rderr", 32'(RD_ERR_o), 32'd1);
        chk("pe.wrerr", 32'(WR_ERR_o), 32'd0);
        chk("pe.valid", 32'(DO_VALID_o), 32'd0);
        chk("pe.level", 32'(LEVEL_o), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        chk_pop("pe.pop", 8'h5A);
        chk("pe.rderr_clr", 32'(RD_ERR_o), 32'd0);
        chk_flags("pe.end", 0);

        // Steady level 10 over 100 push+pop cycles: pointers wrap repeatedly
        wr_val = 8'h10;
        rd_val = 8'h10;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, wr_val, 1'b0);
            wr_val++;
        end
        chk("steady.level0", 32'(LEVEL_o), 32'd10);
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, wr_val, 1'b1);
            wr_val++;
            chk_pop("steady", rd_val);
            rd_val++;
            chk("steady.level", 32'(LEVEL_o), 32'd10);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            chk_pop("steadydrain", rd_val);
            rd_val++;
        end
        chk_flags("steady.end", 0);

        // Reset mid-operation
        for (int i = 0; i < 20; i++)
            drive(1'b1, 8'(8'hC0 + i), 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        chk_pop("prerst", 8'hC0);
        rst = 1'b0;
        drive(1'b1, 8'h11, 1'b1);
        chk_flags("midrst", 0);
        chk("midrst.valid", 32'(DO_VALID_o), 32'd0);
        chk("midrst.do", 32'(DO), 32'd0);
        rst = 1'b1;
        drive(1'b1, 8'h3C, 1'b0);
        chk("postrst.level", 32'(LEVEL_o), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        chk_pop("postrst", 8'h3C);
        chk("postrst.empty", 32'(EMPTY_o), 32'd1);
        drive(1'b0, 8'h00, 1'b1);
        chk("postrst.rderr", 32'(RD_ERR_o), 32'd1);
        chk("postrst.valid", 32'(DO_VALID_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
